// File: rtl/ctrl_intersection.sv
// Multi-approach traffic-light controller: round-robin service,
// all-red clearance, night flash mode and internal tick prescaler.
module ctrl_intersection #(
  parameter int N_CH         = 3,
  parameter int CLK_PER_TICK = 100000000,
  parameter int T_ALLRED     = 1,
  parameter int T_RYEL       = 1,
  parameter int T_GREEN      = 5,
  parameter int T_YELLOW     = 2
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [N_CH-1:0]   REQ,
  input  logic              FLASH,
  output logic [3*N_CH-1:0] RGB,
  output logic [N_CH-1:0]   GNT,
  output logic [2:0]        STATE
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (CLK_PER_TICK > 1) ?
                      $clog2(CLK_PER_TICK) : 1;
  localparam int T_A = (T_ALLRED > T_RYEL) ? T_ALLRED : T_RYEL;
  localparam int T_B = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int PW = $clog2(TMAX + 1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b110;
  localparam logic [2:0] L_GRN = 3'b010;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARED  = 3'd1,
    S_RYEL  = 3'd2,
    S_GREEN = 3'd3,
    S_YEL   = 3'd4,
    S_FLASH = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   pre, pre_n;
  logic [PW-1:0]   ph, ph_n;
  logic [PW-1:0]   dur;
  logic [N_CH-1:0] pend, pend_v, pend_n;
  logic [N_CH-1:0] mask, clr, sel_oh;
  logic [IW-1:0]   last, sel_q, sel_c;
  logic            tick, done, ent;
  logic            found;

  assign tick   = (pre == CW'(CLK_PER_TICK - 1));
  assign sel_oh = N_CH'(1) << sel_q;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= S_ARED;
      pre   <= '0;
      ph    <= '0;
      pend  <= '0;
      last  <= IW'(N_CH - 1);
      sel_q <= '0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      ph    <= ph_n;
      pend  <= pend_n;
      if (state_n == S_RYEL && state != S_RYEL)
        sel_q <= sel_c;
      if (state_n == S_GREEN && state != S_GREEN)
        last <= sel_q;
    end
  end

  always_comb begin
    dur = PW'(1);
    case (state)
      S_ARED:  dur = PW'(T_ALLRED);
      S_RYEL:  dur = PW'(T_RYEL);
      S_GREEN: dur = PW'(T_GREEN);
      S_YEL:   dur = PW'(T_YELLOW);
      default: dur = PW'(1);
    endcase
  end

  assign done = tick && (ph == dur - PW'(1));

  // The selected approach cannot re-request itself while it is being served.
  always_comb begin
    mask = '0;
    if (state == S_RYEL || state == S_GREEN)
      mask = sel_oh;
  end

  assign pend_v = pend | (REQ & ~mask);

  always_comb begin
    sel_c = last;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      automatic int idx = (int'(last) + k) % N_CH;
      if (!found && pend_v[idx]) begin
        sel_c = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (FLASH)
          state_n = S_FLASH;
        else if (|pend_v)
          state_n = S_RYEL;
      end
      S_ARED: begin
        if (done) begin
          if (FLASH)
            state_n = S_FLASH;
          else if (|pend_v)
            state_n = S_RYEL;
          else
            state_n = S_IDLE;
        end
      end
      S_RYEL: begin
        if (done)
          state_n = S_GREEN;
      end
      S_GREEN: begin
        if (done)
          state_n = S_YEL;
      end
      S_YEL: begin
        if (done)
          state_n = S_ARED;
      end
      S_FLASH: begin
        if (!FLASH)
          state_n = S_ARED;
      end
      default: state_n = S_ARED;
    endcase
  end

  assign ent = (state_n != state);

  always_comb begin
    clr = '0;
    if (state == S_RYEL && state_n == S_GREEN)
      clr = sel_oh;
  end

  assign pend_n = pend_v & ~clr;

  // In FLASH the phase count runs freely; its LSB gives the blink.
  always_comb begin
    pre_n = pre;
    ph_n  = ph;
    if (ent) begin
      pre_n = '0;
      ph_n  = '0;
    end else if (tick) begin
      pre_n = '0;
      ph_n  = ph + PW'(1);
    end else begin
      pre_n = pre + CW'(1);
    end
  end

  always_comb begin
    RGB = '0;
    GNT = '0;
    for (int i = 0; i < N_CH; i++) begin
      automatic logic [2:0] lamp = L_RED;
      automatic logic       hit  = (sel_q == IW'(i));
      unique case (1'b1)
        (state == S_FLASH):
          lamp = ph[0] ? L_OFF : L_YEL;
        (hit && state == S_RYEL):
          lamp = L_YEL;
        (hit && state == S_GREEN):
          lamp = L_GRN;
        (hit && state == S_YEL):
          lamp = L_YEL;
        default:
          lamp = L_RED;
      endcase
      RGB[3*i +: 3] = lamp;
    end
    if (state == S_GREEN)
      GNT = sel_oh;
  end

  assign STATE = state;

endmodule

// File: tb/tb_ctrl_intersection.sv
// Directed bench for ctrl_intersection: phase-by-phase
// checks of STATE, RGB and GNT against hand-computed values.
module tb_ctrl_intersection;

  logic       CLK;
  logic       RES;
  logic [2:0] REQ;
  logic       FLASH;
  logic [8:0] RGB;
  logic [2:0] GNT;
  logic [2:0] STATE;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] ALLR = 9'b100_100_100;
  localparam logic [8:0] A0Y  = 9'b100_100_110;
  localparam logic [8:0] A0G  = 9'b100_100_010;
  localparam logic [8:0] A1Y  = 9'b100_110_100;
  localparam logic [8:0] A1G  = 9'b100_010_100;
  localparam logic [8:0] A2Y  = 9'b110_100_100;
  localparam logic [8:0] A2G  = 9'b010_100_100;
  localparam logic [8:0] FON  = 9'b110_110_110;
  localparam logic [8:0] FOFF = 9'b000_000_000;

  ctrl_intersection #(
    .N_CH(3),
    .CLK_PER_TICK(2),
    .T_ALLRED(1),
    .T_RYEL(1),
    .T_GREEN(3),
    .T_YELLOW(2)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .REQ(REQ),
    .FLASH(FLASH),
    .RGB(RGB),
    .GNT(GNT),
    .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st,
                     input logic [8:0] rgb, input logic [2:0] gnt);
    total++;
    assert ({STATE, RGB, GNT} === {st, rgb, gnt})
    else begin
      bad++;
      $error("FAIL %s: got st=%0d rgb=%b gnt=%b want st=%0d rgb=%b gnt=%b",
             tag, STATE, RGB, GNT, st, rgb, gnt);
    end
  endtask

  task automatic phase(input string tag, input logic [2:0] st,
                       input logic [8:0] rgb, input logic [2:0] gnt,
                       input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]", tag, i), st, rgb, gnt);
      step();
    end
  endtask

  initial begin
    RES   = 1'b1;
    REQ   = 3'b000;
    FLASH = 1'b0;
    step();
    RES = 1'b0;

    // 1. reset
    phase("rst_ared", 3'd1, ALLR, 3'b000, 2);
    phase("rst_idle", 3'd0, ALLR, 3'b000, 3);

    // 2. single request on approach 1
    REQ = 3'b010;
    step();
    REQ = 3'b000;
    phase("s_ryel", 3'd2, A1Y, 3'b000, 2);
    phase("s_grn", 3'd3, A1G, 3'b010, 6);
    phase("s_yel", 3'd4, A1Y, 3'b000, 4);
    phase("s_ared", 3'd1, ALLR, 3'b000, 2);
    phase("s_idle", 3'd0, ALLR, 3'b000, 2);

    // 3. round robin from last=1: 2 then 0
    REQ = 3'b101;
    step();
    REQ = 3'b000;
    phase("rr_ryel2", 3'd2, A2Y, 3'b000, 2);
    phase("rr_grn2", 3'd3, A2G, 3'b100, 6);
    phase("rr_yel2", 3'd4, A2Y, 3'b000, 4);
    phase("rr_ared", 3'd1, ALLR, 3'b000, 2);
    phase("rr_ryel0", 3'd2, A0Y, 3'b000, 2);
    phase("rr_grn0", 3'd3, A0G, 3'b001, 6);
    phase("rr_yel0", 3'd4, A0Y, 3'b000, 4);
    phase("rr_ared2", 3'd1, ALLR, 3'b000, 2);
    phase("rr_idle", 3'd0, ALLR, 3'b000, 2);

    // 4. requests during approach 1 green
    REQ = 3'b010;
    step();
    REQ = 3'b000;
    phase("g_ryel1", 3'd2, A1Y, 3'b000, 2);
    phase("g_grn1a", 3'd3, A1G, 3'b010, 1);
    REQ = 3'b010;
    phase("g_grn1b", 3'd3, A1G, 3'b010, 1);
    REQ = 3'b001;
    phase("g_grn1c", 3'd3, A1G, 3'b010, 1);
    REQ = 3'b000;
    phase("g_grn1d", 3'd3, A1G, 3'b010, 3);
    phase("g_yel1", 3'd4, A1Y, 3'b000, 4);
    phase("g_ared", 3'd1, ALLR, 3'b000, 2);
    phase("g_ryel0", 3'd2, A0Y, 3'b000, 2);
    phase("g_grn0", 3'd3, A0G, 3'b001, 6);
    phase("g_yel0", 3'd4, A0Y, 3'b000, 4);
    phase("g_ared2", 3'd1, ALLR, 3'b000, 2);
    phase("g_idle", 3'd0, ALLR, 3'b000, 3);

    // 5. flash entry mid-green, exit, pending served
    REQ = 3'b001;
    step();
    REQ = 3'b000;
    phase("f_ryel0", 3'd2, A0Y, 3'b000, 2);
    phase("f_grn0a", 3'd3, A0G, 3'b001, 3);
    FLASH = 1'b1;
    phase("f_grn0b", 3'd3, A0G, 3'b001, 3);
    phase("f_yel0", 3'd4, A0Y, 3'b000, 4);
    phase("f_ared", 3'd1, ALLR, 3'b000, 2);
    phase("f_on1", 3'd5, FON, 3'b000, 2);
    REQ = 3'b100;
    phase("f_off1a", 3'd5, FOFF, 3'b000, 1);
    REQ = 3'b000;
    phase("f_off1b", 3'd5, FOFF, 3'b000, 1);
    phase("f_on2", 3'd5, FON, 3'b000, 2);
    phase("f_off2", 3'd5, FOFF, 3'b000, 2);
    phase("f_on3a", 3'd5, FON, 3'b000, 1);
    FLASH = 1'b0;
    phase("f_on3b", 3'd5, FON, 3'b000, 1);
    phase("f_exit", 3'd1, ALLR, 3'b000, 2);
    phase("f_ryel2", 3'd2, A2Y, 3'b000, 2);
    phase("f_grn2", 3'd3, A2G, 3'b100, 6);
    phase("f_yel2", 3'd4, A2Y, 3'b000, 4);
    phase("f_ared2", 3'd1, ALLR, 3'b000, 2);
    phase("f_idle", 3'd0, ALLR, 3'b000, 2);

    // 6. reset during approach 2 green with pend=001
    REQ = 3'b100;
    step();
    REQ = 3'b000;
    phase("r_ryel2", 3'd2, A2Y, 3'b000, 2);
    REQ = 3'b001;
    phase("r_grn2a", 3'd3, A2G, 3'b100, 1);
    REQ = 3'b000;
    phase("r_grn2b", 3'd3, A2G, 3'b100, 1);
    RES = 1'b1;
    step();
    RES = 1'b0;
    phase("r_ared", 3'd1, ALLR, 3'b000, 2);
    phase("r_idle", 3'd0, ALLR, 3'b000, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
